// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Brief    : Shared Y86-64 constants and register-ID decode helper.
// Revision : 1.0
// ============================================================================
package y86_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } dec_ids_t;

    // Any icode not matched (including illegal C..F) leaves all IDs at RNONE.
    function automatic dec_ids_t decode_ids(input logic [3:0] icode,
                                            input logic [3:0] ra,
                                            input logic [3:0] rb,
                                            input logic       cnd);
        dec_ids_t d;
        d = {4{RNONE}};
        case (icode)
            I_RRMOVQ: begin d.src_a = ra; d.dst_e = cnd ? rb : RNONE; end
            I_IRMOVQ: begin d.dst_e = rb; end
            I_RMMOVQ: begin d.src_a = ra; d.src_b = rb; end
            I_MRMOVQ: begin d.src_b = rb; d.dst_m = ra; end
            I_OPQ:    begin d.src_a = ra; d.src_b = rb; d.dst_e = rb; end
            I_CALL:   begin d.src_b = RRSP; d.dst_e = RRSP; end
            I_RET:    begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; end
            I_PUSHQ:  begin d.src_a = ra; d.src_b = RRSP; d.dst_e = RRSP; end
            I_POPQ:   begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; d.dst_m = ra; end
            default:  d = {4{RNONE}};
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/y86_regfile.sv
`default_nettype none
// ============================================================================
// Module   : y86_regfile
// Brief    : 15x64 register file, two async reads, E/M writes (M wins), debug.
// Revision : 1.0
// ============================================================================
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [XLEN-1:0] RSP_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we_e,
    input  logic [3:0]      i_dst_e,
    input  logic [XLEN-1:0] i_val_e,
    input  logic            i_we_m,
    input  logic [3:0]      i_dst_m,
    input  logic [XLEN-1:0] i_val_m,
    input  logic [3:0]      i_src_a,
    input  logic [3:0]      i_src_b,
    output logic [XLEN-1:0] o_val_a,
    output logic [XLEN-1:0] o_val_b,
    input  logic [3:0]      i_dbg_sel,
    output logic [XLEN-1:0] o_dbg_data
);

    logic [XLEN-1:0] r_regs [0:NREGS-1];

    // M write is issued last so it takes the register when both ports target it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[RRSP] <= RSP_INIT;
        end else begin
            if (i_we_e && (i_dst_e != RNONE)) begin
                r_regs[i_dst_e] <= i_val_e;
            end
            if (i_we_m && (i_dst_m != RNONE)) begin
                r_regs[i_dst_m] <= i_val_m;
            end
        end
    end

    assign o_val_a    = (i_src_a   == RNONE) ? '0 : r_regs[i_src_a];
    assign o_val_b    = (i_src_b   == RNONE) ? '0 : r_regs[i_src_b];
    assign o_dbg_data = (i_dbg_sel == RNONE) ? '0 : r_regs[i_dbg_sel];

endmodule
`default_nettype wire

// File: rtl/decode_writeback.sv
`default_nettype none
// ============================================================================
// Module   : decode_writeback
// Brief    : Y86-64 SEQ decode/write-back stage: register-ID decode + regfile.
// Revision : 1.0
// ============================================================================
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_data
);

    dec_ids_t w_ids;

    assign w_ids = decode_ids(icode, rA, rB, cnd);
    assign srcA  = w_ids.src_a;
    assign srcB  = w_ids.src_b;
    assign dstE  = w_ids.dst_e;
    assign dstM  = w_ids.dst_m;

    y86_regfile #(
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk        (clk),
        .rst        (reset),
        .i_we_e     (wb_en),
        .i_dst_e    (w_ids.dst_e),
        .i_val_e    (valE),
        .i_we_m     (wb_en),
        .i_dst_m    (w_ids.dst_m),
        .i_val_m    (valM),
        .i_src_a    (w_ids.src_a),
        .i_src_b    (w_ids.src_b),
        .o_val_a    (valA),
        .o_val_b    (valB),
        .i_dbg_sel  (dbg_sel),
        .o_dbg_data (dbg_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_decode_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_writeback
// Brief    : Directed self-checking bench for decode_writeback (RSP_INIT=0x100).
// Revision : 1.0
// ============================================================================
module tb_decode_writeback;

    localparam logic [63:0] C_RSP_INIT = 64'h100;
    localparam logic [63:0] C_BIG      = 64'd746454534454545127;
    localparam logic [63:0] C_R3       = 64'h3333_4444_5555_6666;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  icode, rA, rB, dbg_sel;
    logic        cnd, wb_en;
    logic [63:0] valE, valM, valA, valB, dbg_data;
    logic [3:0]  srcA, srcB, dstE, dstM;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb [$];

    decode_writeback #(.RSP_INIT(C_RSP_INIT)) dut (
        .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en), .valA(valA), .valB(valB),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_val(input logic [63:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s observed=%h required=<empty scoreboard>", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h required=%h", tag, obs, e);
            end
        end
    endtask

    task automatic dbg(input logic [3:0] sel, input string tag, input logic [63:0] e);
        dbg_sel = sel;
        #1;
        exp_val(e);
        chk(tag, dbg_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wb_en = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
        cnd = 1'b0; valE = '0; valM = '0; dbg_sel = 4'h4;
        tick(); tick();
        reset = 1'b0;
        #1;
        // Reset state
        dbg(4'h4, "reset_rsp", C_RSP_INIT);
        dbg(4'h0, "reset_r0", 64'h0);
        dbg(4'hF, "dbg_rnone", 64'h0);
        exp_val(64'hF); chk("nop_srcA", srcA);

        // irmovq into reg2, no bypass before the edge
        icode = 4'h3; rB = 4'h2; valE = C_BIG; wb_en = 1'b1;
        #1;
        exp_val(64'h2); chk("irmov_dstE", dstE);
        exp_val(64'hF); chk("irmov_srcB", srcB);
        dbg(4'h2, "irmov_before_edge", 64'h0);
        tick();
        dbg(4'h2, "irmov_after_edge", C_BIG);

        // preload reg3, then OPq reads both
        rB = 4'h3; valE = C_R3;
        tick();
        icode = 4'h6; rA = 4'h2; rB = 4'h3; wb_en = 1'b0;
        #1;
        exp_val(64'h2); chk("opq_srcA", srcA);
        exp_val(64'h3); chk("opq_srcB", srcB);
        exp_val(64'h3); chk("opq_dstE", dstE);
        exp_val(64'hF); chk("opq_dstM", dstM);
        exp_val(C_BIG); chk("opq_valA", valA);
        exp_val(C_R3);  chk("opq_valB", valB);

        // cmov not taken then taken
        icode = 4'h2; rA = 4'h1; rB = 4'h5; cnd = 1'b0; valE = 64'h55; wb_en = 1'b1;
        #1;
        exp_val(64'hF); chk("cmov_nt_dstE", dstE);
        exp_val(64'h1); chk("cmov_srcA", srcA);
        tick();
        dbg(4'h5, "cmov_nt_reg5", 64'h0);
        cnd = 1'b1;
        #1;
        exp_val(64'h5); chk("cmov_t_dstE", dstE);
        tick();
        dbg(4'h5, "cmov_t_reg5", 64'h55);

        // popq %rsp: M port wins
        icode = 4'hB; rA = 4'h4; rB = 4'hF; valE = 64'h108; valM = 64'hDEAD;
        #1;
        exp_val(64'h4); chk("popq_srcA", srcA);
        exp_val(64'h4); chk("popq_dstM", dstM);
        exp_val(64'h4); chk("popq_dstE", dstE);
        exp_val(C_RSP_INIT); chk("popq_valB", valB);
        tick();
        dbg(4'h4, "popq_rsp", 64'hDEAD);

        // mrmovq writes through the M port only
        icode = 4'h5; rA = 4'h6; rB = 4'h2; valE = 64'h77; valM = 64'hBEEF;
        #1;
        exp_val(64'h2); chk("mrmov_srcB", srcB);
        exp_val(64'hF); chk("mrmov_dstE", dstE);
        tick();
        dbg(4'h6, "mrmov_reg6", 64'hBEEF);

        // illegal icode
        icode = 4'hC; rA = 4'h1; rB = 4'h2;
        #1;
        exp_val(64'hF); chk("ill_srcA", srcA);
        exp_val(64'hF); chk("ill_srcB", srcB);
        exp_val(64'hF); chk("ill_dstE", dstE);
        exp_val(64'hF); chk("ill_dstM", dstM);

        // wb_en low blocks the write, decode still updates
        icode = 4'h3; rB = 4'h1; valE = 64'hAAAA; wb_en = 1'b0;
        #1;
        exp_val(64'h1); chk("nowb_dstE", dstE);
        tick();
        dbg(4'h1, "nowb_reg1", 64'h0);

        // reset overrides a same-cycle write
        reset = 1'b1; wb_en = 1'b1; rB = 4'h2; valE = 64'hFFFF;
        tick();
        reset = 1'b0; wb_en = 1'b0;
        dbg(4'h2, "rst_reg2", 64'h0);
        dbg(4'h4, "rst_rsp", C_RSP_INIT);
        dbg(4'h6, "rst_reg6", 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
